// File: rtl/instr_trace_buf_pkg.sv
// Shared types and constants for the instruction trace buffer.
// The decoder blanks all six digits when it sees INSTR_BLANK.
package instr_trace_pkg;

   typedef enum logic {
      LIVE   = 1'b0,
      FROZEN = 1'b1
   } trace_state_t;

   localparam logic [31:0] INSTR_BLANK = 32'h0;

endpackage

// File: rtl/instr_trace_buf_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the accepted 1->0 transition of the debounced level.
module key_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // Released (high) is the reset level everywhere so no pulse follows reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync2;
               cnt   <= '0;
               press <= ~sync2;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/instr_trace_buf.sv
// Circular history of core instructions; freezing stops capture and lets the
// user browse older/newer entries, the selected word is registered onto Instr.
module instr_trace_buf
   import instr_trace_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int DEB_CYCLES = 500000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     instr_valid,
   input  logic [31:0]              instr_in,
   input  logic                     key_freeze_n,
   input  logic                     key_prev_n,
   input  logic                     key_next_n,
   output logic [31:0]              Instr,
   output logic                     frozen,
   output logic [$clog2(DEPTH)-1:0] ofs,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   // instr_valid is a valid-only strobe with no backpressure: a word offered
   // while FROZEN is simply dropped.
   trace_state_t  state_q;
   trace_state_t  state_d;
   logic [AW-1:0] ofs_d;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_idx;
   logic          wr_en;
   logic          freeze_p;
   logic          prev_p;
   logic          next_p;
   logic [31:0]   mem [DEPTH];

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_freeze (
      .clk   (clk),
      .reset (reset),
      .key_n (key_freeze_n),
      .press (freeze_p)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_prev (
      .clk   (clk),
      .reset (reset),
      .key_n (key_prev_n),
      .press (prev_p)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (
      .clk   (clk),
      .reset (reset),
      .key_n (key_next_n),
      .press (next_p)
   );

   // Freeze beats navigation; simultaneous prev/next cancel out.
   always_comb begin
      state_d = state_q;
      ofs_d   = ofs;
      case (state_q)
         LIVE: begin
            if (freeze_p) begin
               state_d = FROZEN;
               ofs_d   = '0;
            end
         end
         FROZEN: begin
            if (freeze_p) begin
               state_d = LIVE;
               ofs_d   = '0;
            end else if ((count != '0) && (prev_p != next_p)) begin
               if (prev_p && (({1'b0, ofs} + (AW+1)'(1)) < count)) begin
                  ofs_d = ofs + AW'(1);
               end else if (next_p && (ofs != '0)) begin
                  ofs_d = ofs - AW'(1);
               end
            end
         end
         default: begin
            state_d = LIVE;
            ofs_d   = '0;
         end
      endcase
   end

   assign wr_en  = (state_q == LIVE) && instr_valid;
   assign rd_idx = wr_ptr - AW'(1) - ofs;
   assign frozen = (state_q == FROZEN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LIVE;
         ofs     <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         Instr   <= INSTR_BLANK;
      end else begin
         state_q <= state_d;
         ofs     <= ofs_d;
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != (AW+1)'(DEPTH)) begin
               count <= count + (AW+1)'(1);
            end
         end
         Instr <= (count == '0) ? INSTR_BLANK : mem[rd_idx];
      end
   end

   // History storage is never cleared; count==0 hides stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= instr_in;
      end
   end

endmodule

// File: tb/tb_instr_trace_buf.sv
// Directed bench for instr_trace_buf with short debounce (DEB_CYCLES=4).
module tb_instr_trace_buf;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [31:0] instr_in;
   logic        key_freeze_n;
   logic        key_prev_n;
   logic        key_next_n;
   logic [31:0] Instr;
   logic        frozen;
   logic [2:0]  ofs;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   instr_trace_buf #(.DEPTH(8), .DEB_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr_valid  (instr_valid),
      .instr_in     (instr_in),
      .key_freeze_n (key_freeze_n),
      .key_prev_n   (key_prev_n),
      .key_next_n   (key_next_n),
      .Instr        (Instr),
      .frozen       (frozen),
      .ofs          (ofs),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Hold the selected keys low long enough for pulse + state + Instr update.
   task automatic press(input logic f, input logic p, input logic n);
      key_freeze_n = ~f;
      key_prev_n   = ~p;
      key_next_n   = ~n;
      repeat (8) tick();
      key_freeze_n = 1'b1;
      key_prev_n   = 1'b1;
      key_next_n   = 1'b1;
      repeat (8) tick();
   endtask

   task automatic write_word(input logic [31:0] w);
      instr_valid = 1'b1;
      instr_in    = w;
      tick();
      instr_valid = 1'b0;
   endtask

   int rise;
   logic seen;

   initial begin
      reset        = 1'b1;
      instr_valid  = 1'b0;
      instr_in     = 32'h0;
      key_freeze_n = 1'b1;
      key_prev_n   = 1'b1;
      key_next_n   = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();

      // Reset state and LIVE navigation ignored.
      chk("rst_instr", Instr, 32'h0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_frozen", 32'(frozen), 32'd0);
      chk("rst_ofs", 32'(ofs), 32'd0);
      press(1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      chk("live_nav_ofs", 32'(ofs), 32'd0);
      chk("live_nav_instr", Instr, 32'h0);

      // Two writes, each visible two cycles after instr_valid.
      write_word(32'h00500093);
      chk("lat1_early", Instr, 32'h0);
      tick();
      chk("lat2_first", Instr, 32'h00500093);
      write_word(32'h40208133);
      tick();
      chk("second_word", Instr, 32'h40208133);
      chk("count2", 32'(count), 32'd2);

      // Ten more writes wrap the buffer.
      for (int i = 0; i < 10; i++) write_word(32'h10000000 + 32'(i));
      tick();
      chk("wrap_count", 32'(count), 32'd8);
      chk("wrap_newest", Instr, 32'h10000009);

      press(1'b1, 1'b0, 1'b0);
      chk("freeze_frozen", 32'(frozen), 32'd1);
      chk("freeze_instr", Instr, 32'h10000009);
      press(1'b0, 1'b1, 1'b0);
      chk("prev1_instr", Instr, 32'h10000008);
      for (int i = 0; i < 8; i++) press(1'b0, 1'b1, 1'b0);
      chk("prev_sat_ofs", 32'(ofs), 32'd7);
      chk("prev_sat_instr", Instr, 32'h10000002);
      for (int i = 0; i < 7; i++) press(1'b0, 1'b0, 1'b1);
      chk("next_ofs", 32'(ofs), 32'd0);
      chk("next_instr", Instr, 32'h10000009);
      press(1'b0, 1'b0, 1'b1);
      chk("next_sat_ofs", 32'(ofs), 32'd0);

      // Writes while frozen are dropped.
      for (int i = 0; i < 3; i++) begin
         write_word(32'hdead0000 + 32'(i));
         tick();
      end
      chk("frz_wr_count", 32'(count), 32'd8);
      chk("frz_wr_instr", Instr, 32'h10000009);
      press(1'b0, 1'b1, 1'b0);
      chk("frz_wr_older", Instr, 32'h10000008);
      press(1'b1, 1'b0, 1'b0);
      chk("unfreeze_frozen", 32'(frozen), 32'd0);
      chk("unfreeze_ofs", 32'(ofs), 32'd0);
      chk("unfreeze_instr", Instr, 32'h10000009);

      // Freeze pulse coincides with instr_valid: write lands, then freeze.
      key_freeze_n = 1'b0;
      repeat (6) tick();
      write_word(32'h00a00113);
      tick();
      chk("frz_same_frozen", 32'(frozen), 32'd1);
      chk("frz_same_instr", Instr, 32'h00a00113);
      key_freeze_n = 1'b1;
      repeat (8) tick();

      // Unfreeze pulse coincides with instr_valid: write dropped.
      key_freeze_n = 1'b0;
      repeat (6) tick();
      write_word(32'hbad00bad);
      tick();
      chk("unfrz_same_frozen", 32'(frozen), 32'd0);
      chk("unfrz_same_instr", Instr, 32'h00a00113);
      key_freeze_n = 1'b1;
      repeat (8) tick();

      // Simultaneous prev+next, and freeze together with prev.
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      chk("nav1_instr", Instr, 32'h10000009);
      press(1'b0, 1'b1, 1'b1);
      chk("prevnext_ofs", 32'(ofs), 32'd1);
      chk("prevnext_instr", Instr, 32'h10000009);
      press(1'b1, 1'b1, 1'b0);
      chk("frzprev_frozen", 32'(frozen), 32'd0);
      chk("frzprev_ofs", 32'(ofs), 32'd0);
      chk("frzprev_instr", Instr, 32'h00a00113);

      // Reset mid-browse takes effect without a clock edge.
      press(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0);
      chk("pre_rst_ofs", 32'(ofs), 32'd3);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_instr", Instr, 32'h0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_frozen", 32'(frozen), 32'd0);
      chk("arst_ofs", 32'(ofs), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Bouncing freeze key: one accepted press, frozen 7 edges into the hold.
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         key_freeze_n = 1'b0;
         tick();
         seen = seen | frozen;
         tick();
         seen = seen | frozen;
         key_freeze_n = 1'b1;
         tick();
         seen = seen | frozen;
         tick();
         seen = seen | frozen;
      end
      chk("bounce_quiet", 32'(seen), 32'd0);
      key_freeze_n = 1'b0;
      rise = 0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (frozen && rise == 0) rise = k;
      end
      chk("bounce_latency", 32'(rise), 32'd7);
      chk("bounce_single", 32'(frozen), 32'd1);
      key_freeze_n = 1'b1;
      repeat (8) tick();

      // Empty history: navigation while frozen does nothing.
      press(1'b0, 1'b1, 1'b0);
      chk("empty_nav_ofs", 32'(ofs), 32'd0);
      chk("empty_nav_instr", Instr, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_trace_buf.md
Name: instr_trace_buf

Overview:
- Sits directly upstream of the instruction-mnemonic decoder on the FPGA board.
- Captures instructions reported by the core into a small circular history buffer.
- Presents one selected 32-bit word on Instr for the decoder to display on HEX0–HEX5.
- Three push buttons freeze the capture and let the user browse older and newer entries.

Parameters:
- DEPTH, 8: history entries; must be a power of 2 and ≥2.
- DEB_CYCLES, 500000: cycles a key must stay stable before the change is accepted (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  core presents a new instruction this cycle
- instr_in  in  32  instruction word from the core
- key_freeze_n  in  1  raw push button, active-low; toggles LIVE/FROZEN
- key_prev_n  in  1  raw push button, active-low; step to an older entry
- key_next_n  in  1  raw push button, active-low; step to a newer entry
- Instr  out  32  registered word sent to the decoder
- frozen  out  1  high while in FROZEN
- ofs  out  $clog2(DEPTH)  browse offset; 0 = newest entry
- count  out  $clog2(DEPTH)+1  number of valid entries, saturates at DEPTH

Behaviour:
- Reset (asynchronous):
  - state=LIVE; wr_ptr=0; count=0; ofs=0; Instr=32'h0; frozen=0.
  - Debouncer state returns to "released".
  - Memory contents are not cleared; they are unreachable because count=0.
- Key path, identical for each key:
  - 2-flop synchronizer.
  - Stability counter: the debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a 1-cycle pulse on the debounced 1→0 transition. Release generates nothing.
  - Latency from a clean press edge to the pulse is 2+DEB_CYCLES cycles.
- Capture:
  - While state==LIVE (current-cycle register value) and instr_valid: mem[wr_ptr]<=instr_in; wr_ptr<=wr_ptr+1 mod DEPTH; count<=min(count+1, DEPTH).
  - While FROZEN, instr_valid is ignored and the instruction is dropped.
- State machine:
  - LIVE --freeze pulse--> FROZEN, with ofs=0.
  - FROZEN --freeze pulse--> LIVE, with ofs=0.
  - The freeze pulse and instr_valid in the same cycle while LIVE: the write is committed, then the block freezes.
  - The unfreeze pulse and instr_valid in the same cycle: the write is dropped.
- Navigation (FROZEN only):
  - prev pulse: ofs<=ofs+1 if ofs<count-1, else unchanged (saturates at the oldest entry).
  - next pulse: ofs<=ofs-1 if ofs>0, else unchanged.
  - prev and next in the same cycle: neither acts.
  - Freeze pulse in the same cycle as any navigation pulse: freeze wins and navigation is ignored.
  - count==0: navigation is ignored.
  - In LIVE, navigation pulses are ignored.
- Output:
  - Instr is registered. Each cycle: Instr <= (count==0) ? 32'h0 : mem[(wr_ptr-1-ofs) mod DEPTH], computed from the pre-update register values.
  - Instr therefore reflects a write, ofs change or state change exactly 1 cycle after the register update, i.e. 2 cycles after instr_valid.
  - 32'h0 (opcode 0) makes the decoder blank all digits.
- Wrap-around: after more than DEPTH writes, the oldest entry is overwritten and count stays at DEPTH. Index arithmetic is modulo DEPTH using natural pointer wrap.
- Reset mid-browse: returns to LIVE with an empty history immediately.

Decomposition:
- Package instr_trace_pkg contains:
  - typedef enum logic {LIVE, FROZEN} trace_state_t
  - localparam logic [31:0] INSTR_BLANK = 32'h0
- Sub-module key_debounce: synchronizer, stability counter and falling-edge pulse. Parameter DEB_CYCLES. Ports clk, reset, key_n, press. Instantiated 3 times.

Test Plan (DEB_CYCLES=4):
- Reset, then no traffic -> Instr=0, count=0, frozen=0. Presses of prev/next have no effect.
- LIVE: write 0x00500093, then 0x40208133 -> Instr=0x00500093 two cycles after the first write, then 0x40208133 two cycles after the second; count=2.
- Write 10 words W0..W9 with DEPTH=8 -> count=8. Freeze; press prev 9 times -> ofs saturates at 7 and Instr=W2. Press next 7 times -> Instr=W9.
- FROZEN with instr_valid pulsed 3 times -> count and entries unchanged. Unfreeze -> Instr=newest pre-freeze word, ofs=0.
- Bouncing key (toggle every 2 cycles for 20 cycles, then hold low) -> exactly one press pulse, 6 cycles after the hold begins.
- prev and next pulses in the same cycle -> ofs unchanged. Freeze and prev in the same cycle -> state toggles and ofs=0. Assert reset while FROZEN at ofs=3 -> all outputs return to reset values immediately.
